mini_mem_responder: RTL



---
 rtl/mini_mem_pkg.sv | 32 +++
 rtl/mini_mem_array.sv | 59 +++++
 rtl/mini_mem_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mini_mem_pkg.sv
// Shared types and widths for the mini CPU memory responder.
// Optional feature: MINI_MEM_WRITE_PROTECT_EN (see mini_mem_responder).
package mini_mem_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned FADDR_W = 16;
  localparam int unsigned DADDR_W = 8;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  // Wait-state counts above the counter range saturate.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int unsigned lat);
    logic [CNT_W-1:0] cnt;
    if (lat > 15) begin
      cnt = 4'hF;
    end else begin
      cnt = lat[CNT_W-1:0];
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mini_mem_array.sv
// Unified 16-bit word store: one write port (preload has priority over the core)
// and one read port whose result is registered into a per-requester output register.
module mini_mem_array
  import mini_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_prog_we,
  input  logic [DEPTH_LOG2-1:0] i_prog_addr,
  input  logic [WORD_W-1:0]     i_prog_data,
  input  logic                  i_core_we,
  input  logic [DEPTH_LOG2-1:0] i_core_addr,
  input  logic [WORD_W-1:0]     i_core_wdata,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  input  logic                  i_rd_fetch,
  input  logic                  i_rd_data,
  output logic [WORD_W-1:0]     o_fetch_rdata,
  output logic [WORD_W-1:0]     o_data_rdata
);

  logic [WORD_W-1:0]     r_mem [0:(1 << DEPTH_LOG2)-1];
  logic [WORD_W-1:0]     r_fetch_rdata;
  logic [WORD_W-1:0]     r_data_rdata;
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_waddr;
  logic [WORD_W-1:0]     w_wdata;

  // A same-edge preload overrides the core write.
  assign w_we    = i_prog_we | i_core_we;
  assign w_waddr = i_prog_we ? i_prog_addr : i_core_addr;
  assign w_wdata = i_prog_we ? i_prog_data : i_core_wdata;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      if (i_rd_fetch) begin
        r_fetch_rdata <= r_mem[i_rd_addr];
      end
      if (i_rd_data) begin
        r_data_rdata <= r_mem[i_rd_addr];
      end
    end
  end

  assign o_fetch_rdata = r_fetch_rdata;
  assign o_data_rdata  = r_data_rdata;

endmodule

// File: rtl/mini_mem_responder.sv
// Fetch/data memory responder with REQ/ACK handshake and programmable wait states.
// Define MINI_MEM_WRITE_PROTECT_EN to block core data writes below PROTECT_BASE (adds DATA_ERR).
module mini_mem_responder
  import mini_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
`ifdef MINI_MEM_WRITE_PROTECT_EN
  ,
  parameter logic [DADDR_W-1:0] PROTECT_BASE = 8'h80
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FETCH_REQ,
  input  logic [FADDR_W-1:0] MAR,
  output logic               FETCH_ACK,
  output logic [WORD_W-1:0]  OUT_MEMORY,
  input  logic               DATA_REQ,
  input  logic               DATA_WE,
  input  logic [DADDR_W-1:0] ADDRESS,
  input  logic [WORD_W-1:0]  IN_ADDRESS_MEMORY,
  output logic               DATA_ACK,
  output logic [WORD_W-1:0]  OUT_ADDRESS_MEMORY,
  input  logic               PROG_WE,
  input  logic [FADDR_W-1:0] PROG_ADDR,
  input  logic [WORD_W-1:0]  PROG_DATA
`ifdef MINI_MEM_WRITE_PROTECT_EN
  ,
  output logic               DATA_ERR
`endif
);

  localparam logic [CNT_W-1:0] LatCnt = lat_to_cnt(LATENCY);
  localparam logic [CNT_W-1:0] CntOne = 4'd1;

  state_e                r_state;
  state_e                w_state_d;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_d;
  logic                  w_access;

  port_e                 r_port;
  logic                  r_we;
  logic                  r_prot;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [WORD_W-1:0]     r_wdata;

  logic [FADDR_W-1:0]    w_daddr_ext;
  logic                  w_accept;
  port_e                 w_req_port;
  logic [DEPTH_LOG2-1:0] w_req_addr;
  logic                  w_req_we;
  logic                  w_req_prot;

  port_e                 w_acc_port;
  logic [DEPTH_LOG2-1:0] w_acc_addr;
  logic                  w_acc_we;
  logic                  w_acc_prot;
  logic [WORD_W-1:0]     w_acc_wdata;
  logic                  w_core_we;
  logic                  w_rd_fetch;
  logic                  w_rd_data;
  logic                  w_unused_hi;

  // Request decode; data wins a simultaneous request.
  assign w_daddr_ext = {{(FADDR_W - DADDR_W){1'b0}}, ADDRESS};
  assign w_accept    = (r_state == StIdle) && (DATA_REQ || FETCH_REQ);
  assign w_req_port  = DATA_REQ ? PORT_DATA : PORT_FETCH;
  assign w_req_addr  = DATA_REQ ? w_daddr_ext[DEPTH_LOG2-1:0] : MAR[DEPTH_LOG2-1:0];
  assign w_req_we    = DATA_REQ & DATA_WE;
`ifdef MINI_MEM_WRITE_PROTECT_EN
  assign w_req_prot  = DATA_REQ & DATA_WE & (ADDRESS < PROTECT_BASE);
`else
  assign w_req_prot  = 1'b0;
`endif

  assign w_unused_hi = ^{MAR[FADDR_W-1:DEPTH_LOG2], PROG_ADDR[FADDR_W-1:DEPTH_LOG2],
                         w_daddr_ext[FADDR_W-1:DEPTH_LOG2]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_access  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_cnt_d = LatCnt;
          if (LatCnt == '0) begin
            w_state_d = StResp;
            w_access  = 1'b1;
          end else begin
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        w_cnt_d = r_cnt - CntOne;
        if (r_cnt == CntOne) begin
          w_state_d = StResp;
          w_access  = 1'b1;
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_port  <= PORT_FETCH;
      r_we    <= 1'b0;
      r_prot  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_port  <= w_req_port;
      r_we    <= w_req_we;
      r_prot  <= w_req_prot;
      r_addr  <= w_req_addr;
      r_wdata <= IN_ADDRESS_MEMORY;
    end
  end

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  assign w_acc_port  = (r_state == StIdle) ? w_req_port : r_port;
  assign w_acc_addr  = (r_state == StIdle) ? w_req_addr : r_addr;
  assign w_acc_we    = (r_state == StIdle) ? w_req_we : r_we;
  assign w_acc_prot  = (r_state == StIdle) ? w_req_prot : r_prot;
  assign w_acc_wdata = (r_state == StIdle) ? IN_ADDRESS_MEMORY : r_wdata;

  assign w_core_we  = w_access & ~RST & (w_acc_port == PORT_DATA) & w_acc_we & ~w_acc_prot;
  assign w_rd_fetch = w_access & (w_acc_port == PORT_FETCH);
  assign w_rd_data  = w_access & (w_acc_port == PORT_DATA) & ~w_acc_we;

  mini_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .i_clk         (CLK),
    .i_rst         (RST),
    .i_prog_we     (PROG_WE),
    .i_prog_addr   (PROG_ADDR[DEPTH_LOG2-1:0]),
    .i_prog_data   (PROG_DATA),
    .i_core_we     (w_core_we),
    .i_core_addr   (w_acc_addr),
    .i_core_wdata  (w_acc_wdata),
    .i_rd_addr     (w_acc_addr),
    .i_rd_fetch    (w_rd_fetch),
    .i_rd_data     (w_rd_data),
    .o_fetch_rdata (OUT_MEMORY),
    .o_data_rdata  (OUT_ADDRESS_MEMORY)
  );

  assign FETCH_ACK = (r_state == StResp) && (r_port == PORT_FETCH);
  assign DATA_ACK  = (r_state == StResp) && (r_port == PORT_DATA);
`ifdef MINI_MEM_WRITE_PROTECT_EN
  assign DATA_ERR  = DATA_ACK & r_prot;
`endif

endmodule
